// File: rtl/mem_arbiter_if.sv
// Fetch/data requester ports and the shared RAM command bus of mem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM view.
interface mem_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int RAM_WIDTH = 16
);
  logic                 if_req_i;
  logic [XLEN-1:0]      if_addr_i;
  logic                 if_gnt_o;
  logic                 if_rvalid_o;
  logic [XLEN-1:0]      if_rdata_o;
  logic                 if_err_o;

  logic                 dm_req_i;
  logic                 dm_we_i;
  logic [1:0]           dm_width_i;
  logic [XLEN-1:0]      dm_addr_i;
  logic [XLEN-1:0]      dm_wdata_i;
  logic                 dm_gnt_o;
  logic                 dm_rvalid_o;
  logic [XLEN-1:0]      dm_rdata_o;
  logic                 dm_err_o;

  logic                 ram_w_rn_o;
  logic [1:0]           ram_width_o;
  logic [RAM_WIDTH-1:0] ram_addr_o;
  logic [XLEN-1:0]      ram_data_o;
  logic [XLEN-1:0]      ram_data_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  dm_req_i, dm_we_i, dm_width_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    output ram_w_rn_o, ram_width_o, ram_addr_o, ram_data_o,
    input  ram_data_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output dm_req_i, dm_we_i, dm_width_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    input  ram_w_rn_o, ram_width_o, ram_addr_o, ram_data_o,
    output ram_data_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store ports for the
// shared RAM: grant in IDLE, one RAM access in SERVE, registered response after.
module mem_arbiter #(
  parameter int XLEN      = 32,
  parameter int RAM_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t               state_q, state_d;
  logic                 prio_dm_q, prio_dm_d;
  logic                 port_dm_q, port_dm_d;
  logic                 we_q, we_d;
  logic [1:0]           width_q, width_d;
  logic [RAM_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic                 fault_q, fault_d;
  logic                 if_rvalid_q, if_rvalid_d;
  logic                 dm_rvalid_q, dm_rvalid_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 dm_wins;
  logic                 sel_we;
  logic [1:0]           sel_width;
  logic [XLEN-1:0]      sel_addr;
  logic                 sel_fault;
  logic                 if_gnt, dm_gnt;
  logic                 ram_we;
  logic [1:0]           ram_width;
  logic [RAM_WIDTH-1:0] ram_addr;
  logic [XLEN-1:0]      ram_wdata;

  // Data port wins when it is the only requester or the pointer favours it.
  assign dm_wins   = bus.dm_req_i & (~bus.if_req_i | prio_dm_q);
  assign sel_we    = dm_wins ? bus.dm_we_i    : 1'b0;
  assign sel_width = dm_wins ? bus.dm_width_i : 2'b10;
  assign sel_addr  = dm_wins ? bus.dm_addr_i  : bus.if_addr_i;

  always_comb begin
    sel_fault = 1'b0;
    if (|sel_addr[XLEN-1:RAM_WIDTH])
      sel_fault = 1'b1;
    case (sel_width)
      2'b01:   if (sel_addr[0]) sel_fault = 1'b1;
      2'b10:   if (|sel_addr[1:0]) sel_fault = 1'b1;
      2'b11:   sel_fault = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_dm_d   = prio_dm_q;
    port_dm_d   = port_dm_q;
    we_d        = we_q;
    width_d     = width_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    ram_we      = 1'b0;
    ram_width   = 2'b10;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      IDLE: begin
        // Gating with reset_n keeps grants low while reset is held.
        if (reset_n && (bus.if_req_i || bus.dm_req_i)) begin
          dm_gnt    = dm_wins;
          if_gnt    = ~dm_wins;
          prio_dm_d = ~dm_wins;
          port_dm_d = dm_wins;
          we_d      = sel_we;
          width_d   = sel_width;
          addr_d    = sel_addr[RAM_WIDTH-1:0];
          wdata_d   = dm_wins ? bus.dm_wdata_i : '0;
          fault_d   = sel_fault;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        state_d = IDLE;
        if (!fault_q) begin
          ram_we    = we_q;
          ram_width = width_q;
          ram_addr  = addr_q;
          ram_wdata = wdata_q;
        end
        if_rvalid_d = ~port_dm_q;
        dm_rvalid_d = port_dm_q;
        rdata_d     = (fault_q || we_q) ? '0 : bus.ram_data_i;
        err_d       = fault_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prio_dm_q   <= 1'b1;
      port_dm_q   <= 1'b0;
      we_q        <= 1'b0;
      width_q     <= 2'b10;
      addr_q      <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_dm_q   <= prio_dm_d;
      port_dm_q   <= port_dm_d;
      we_q        <= we_d;
      width_q     <= width_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.dm_gnt_o    = dm_gnt;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.dm_rvalid_o = dm_rvalid_q;
  assign bus.if_rdata_o  = if_rvalid_q ? rdata_q : '0;
  assign bus.dm_rdata_o  = dm_rvalid_q ? rdata_q : '0;
  assign bus.if_err_o    = if_rvalid_q & err_q;
  assign bus.dm_err_o    = dm_rvalid_q & err_q;
  assign bus.ram_w_rn_o  = ram_we;
  assign bus.ram_width_o = ram_width;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_data_o  = ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-addressed RAM model that
// clears while reset is held.
module tb_mem_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  mem_arbiter_if #(.XLEN(32), .RAM_WIDTH(16)) bus ();

  mem_arbiter #(.XLEN(32), .RAM_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  logic [9:0] ra;

  assign ra = bus.ram_addr_o[9:0];

  always_comb begin
    case (bus.ram_width_o)
      2'b00:   bus.ram_data_i = {24'h0, mem[ra]};
      2'b01:   bus.ram_data_i = {16'h0, mem[ra+10'd1], mem[ra]};
      default: bus.ram_data_i = {mem[ra+10'd3], mem[ra+10'd2], mem[ra+10'd1], mem[ra]};
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bus.ram_w_rn_o) begin
      mem[ra] <= bus.ram_data_o[7:0];
      if (bus.ram_width_o != 2'b00) mem[ra+10'd1] <= bus.ram_data_o[15:8];
      if (bus.ram_width_o == 2'b10) begin
        mem[ra+10'd2] <= bus.ram_data_o[23:16];
        mem[ra+10'd3] <= bus.ram_data_o[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One data-port transaction: grant, SERVE bus check, response check.
  task automatic dm_access(input string tag, input logic we, input logic [1:0] w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic exp_ram_we);
    int n;
    bus.dm_we_i    = we;
    bus.dm_width_i = w;
    bus.dm_addr_i  = a;
    bus.dm_wdata_i = d;
    bus.dm_req_i   = 1'b1;
    #1;
    n = 0;
    while (!bus.dm_gnt_o && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_gnt"}, {31'h0, bus.dm_gnt_o}, 32'h1);
    chk({tag, "_idle_we"}, {31'h0, bus.ram_w_rn_o}, 32'h0);
    @(negedge clk); #1;
    bus.dm_req_i = 1'b0;
    chk({tag, "_serve_we"}, {31'h0, bus.ram_w_rn_o}, {31'h0, exp_ram_we});
    chk({tag, "_serve_addr"}, {16'h0, bus.ram_addr_o}, exp_err ? 32'h0 : {16'h0, a[15:0]});
    @(negedge clk); #1;
    chk({tag, "_rvalid"}, {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h2);
    chk({tag, "_rdata"}, bus.dm_rdata_o, exp_rd);
    chk({tag, "_err"}, {31'h0, bus.dm_err_o}, {31'h0, exp_err});
    $display("dm  we=%0d width=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
             we, w, a, d, bus.dm_rdata_o, bus.dm_err_o);
  endtask

  task automatic if_access(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bus.if_addr_i = a;
    bus.if_req_i  = 1'b1;
    #1;
    n = 0;
    while (!bus.if_gnt_o && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_gnt"}, {31'h0, bus.if_gnt_o}, 32'h1);
    @(negedge clk); #1;
    bus.if_req_i = 1'b0;
    chk({tag, "_serve_we"}, {31'h0, bus.ram_w_rn_o}, 32'h0);
    @(negedge clk); #1;
    chk({tag, "_rvalid"}, {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h1);
    chk({tag, "_rdata"}, bus.if_rdata_o, exp_rd);
    chk({tag, "_err"}, {31'h0, bus.if_err_o}, {31'h0, exp_err});
    $display("if  addr=%h -> rdata=%h err=%0d", a, bus.if_rdata_o, bus.if_err_o);
  endtask

  initial begin
    logic [1:0] exp_g;
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.if_req_i   = 1'b1;
    bus.if_addr_i  = 32'h0;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b0;
    bus.dm_width_i = 2'b10;
    bus.dm_addr_i  = 32'h20;
    bus.dm_wdata_i = 32'h0;

    // Reset held with both requests high.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", {30'h0, bus.dm_gnt_o, bus.if_gnt_o}, 32'h0);
    chk("rst_rvalid", {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h0);
    chk("rst_ram_we", {31'h0, bus.ram_w_rn_o}, 32'h0);
    chk("rst_ram_width", {30'h0, bus.ram_width_o}, 32'h2);
    reset_n = 1'b1;
    #1;
    chk("rel_gnt", {30'h0, bus.dm_gnt_o, bus.if_gnt_o}, 32'h2);
    @(negedge clk); #1;
    bus.dm_req_i = 1'b0;
    bus.if_req_i = 1'b0;
    @(negedge clk); #1;
    chk("rel_rvalid", {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h2);
    chk("rel_rdata", bus.dm_rdata_o, 32'h0);
    $display("dm  reset-release load addr=00000020 -> rdata=%h", bus.dm_rdata_o);

    // Store then load, plus narrower reads of the same word.
    dm_access("st_w", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    dm_access("ld_w", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    dm_access("ld_b", 1'b0, 2'b00, 32'h11, 32'h0, 32'h000000BE, 1'b0, 1'b0);
    dm_access("ld_h", 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1'b0);
    if_access("if_w", 32'h10, 32'hDEADBEEF, 1'b0);

    // Contention: last grant was fetch, so the data port leads.
    bus.dm_we_i    = 1'b0;
    bus.dm_width_i = 2'b10;
    bus.dm_addr_i  = 32'h10;
    bus.if_addr_i  = 32'h10;
    bus.dm_req_i   = 1'b1;
    bus.if_req_i   = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      chk("cont_gnt", {30'h0, bus.dm_gnt_o, bus.if_gnt_o}, {30'h0, exp_g});
      @(negedge clk); #1;
      chk("cont_serve_gnt", {30'h0, bus.dm_gnt_o, bus.if_gnt_o}, 32'h0);
      if (k == 5) begin
        bus.dm_req_i = 1'b0;
        bus.if_req_i = 1'b0;
      end
      @(negedge clk); #1;
      chk("cont_rvalid", {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, {30'h0, exp_g});
      chk("cont_rdata", (k % 2 == 0) ? bus.dm_rdata_o : bus.if_rdata_o, 32'hDEADBEEF);
      $display("contention grant %0d -> port=%s rdata=%h", k, (k % 2 == 0) ? "dm" : "if",
               (k % 2 == 0) ? bus.dm_rdata_o : bus.if_rdata_o);
    end
    #1;
    chk("cont_done_gnt", {30'h0, bus.dm_gnt_o, bus.if_gnt_o}, 32'h0);

    // Faults and range.
    dm_access("flt_h", 1'b1, 2'b01, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, 1'b0);
    dm_access("flt_w11", 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    if_access("flt_if", 32'h2, 32'h0, 1'b1);
    dm_access("range", 1'b0, 2'b10, 32'h00010000, 32'h0, 32'h0, 1'b1, 1'b0);
    dm_access("flt_chk", 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Reset asserted during a store's SERVE cycle.
    bus.dm_we_i    = 1'b1;
    bus.dm_width_i = 2'b10;
    bus.dm_addr_i  = 32'h20;
    bus.dm_wdata_i = 32'h12345678;
    bus.dm_req_i   = 1'b1;
    #1;
    chk("mr_gnt", {31'h0, bus.dm_gnt_o}, 32'h1);
    @(negedge clk); #1;
    bus.dm_req_i = 1'b0;
    chk("mr_serve_we", {31'h0, bus.ram_w_rn_o}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mr_rst_we", {31'h0, bus.ram_w_rn_o}, 32'h0);
    chk("mr_rst_width", {30'h0, bus.ram_width_o}, 32'h2);
    @(negedge clk); #1;
    reset_n = 1'b1;
    chk("mr_rvalid0", {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h0);
    @(negedge clk); #1;
    chk("mr_rvalid1", {30'h0, bus.dm_rvalid_o, bus.if_rvalid_o}, 32'h0);
    $display("dm  store addr=00000020 interrupted by reset");
    dm_access("mr_ld", 1'b0, 2'b10, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
